// File: rtl/serial_pattern_gen_pkg.sv
// Shared definitions for the serial pattern generator.
//   state_e     : FSM state encoding (IDLE/SHIFT/DONE)
//   DATA_W_DEF  : default maximum word length in bits
//   DIV_W_DEF   : default width of the bit-period divisor
package serial_pattern_gen_pkg;

    localparam int DATA_W_DEF = 8;
    localparam int DIV_W_DEF  = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

endpackage

// File: rtl/bit_period_ctr.sv
// Bit-period divider: counts 0..div and pulses tick in the last cycle of each
// period, so one period is div+1 clk cycles.
//   clk   : system clock
//   clr   : asynchronous active-high reset
//   start : restarts the period (count forced to 0 at this edge)
//   div   : period length minus one
//   tick  : high in the final cycle of a period
module bit_period_ctr #(
    parameter int DIV_W = 4
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             start,
    input  logic [DIV_W-1:0] div,
    output logic             tick
);

    logic [DIV_W-1:0] cnt_q;

    assign tick = (cnt_q == div);

    // With div at all-ones the explicit clear and the natural overflow agree,
    // giving a clean 2^DIV_W-cycle period.
    always_ff @(posedge clk or posedge clr) begin
        if (clr)                cnt_q <= '0;
        else if (start || tick) cnt_q <= '0;
        else                    cnt_q <= cnt_q + 1'b1;
    end

endmodule

// File: rtl/serial_pattern_gen.sv
// Serial pattern generator: serializes the low load_len bits of load_data,
// MSB first, one bit every div+1 cycles, optionally repeating the word.
//   clk, clr    : clock and asynchronous active-high reset
//   load_data   : word to send; active field is load_data[len-1:0]
//   load_len    : word length, 0 or >DATA_W means DATA_W
//   load_valid  : load request, accepted while load_ready is high
//   load_ready  : high only in IDLE
//   div         : bit period minus one, sampled at load
//   repeat_en   : re-send the word back-to-back at the end of each pass
//   abort       : synchronous stop while shifting
//   sdout       : serial data, low when idle
//   sdout_stb   : pulse in the first cycle of each bit
//   done        : pulse after a non-repeating word ends
//   busy        : high while shifting
module serial_pattern_gen
    import serial_pattern_gen_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int DIV_W  = DIV_W_DEF
) (
    input  logic                    clk,
    input  logic                    clr,
    input  logic [DATA_W-1:0]       load_data,
    input  logic [$clog2(DATA_W):0] load_len,
    input  logic                    load_valid,
    output logic                    load_ready,
    input  logic [DIV_W-1:0]        div,
    input  logic                    repeat_en,
    input  logic                    abort,
    output logic                    sdout,
    output logic                    sdout_stb,
    output logic                    done,
    output logic                    busy
);

    localparam int LEN_W = $clog2(DATA_W) + 1;
    localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(DATA_W);

    state_e             state_q, state_d;
    logic [DATA_W-1:0]  shreg_q, shreg_d;
    logic [DATA_W-1:0]  saved_q, saved_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [LEN_W-1:0]   bitcnt_q, bitcnt_d;
    logic [DIV_W-1:0]   div_q, div_d;
    logic               sdout_q, sdout_d;
    logic               stb_q, stb_d;
    logic               done_q, done_d;
    logic               busy_q, busy_d;
    logic               ready_q, ready_d;

    logic               handshake;
    logic               tick;
    logic [LEN_W-1:0]   len_eff;
    logic [DATA_W-1:0]  aligned;

    // Left-align the active field so the next bit is always the register MSB.
    assign len_eff   = (load_len == '0 || load_len > LEN_MAX) ? LEN_MAX : load_len;
    assign aligned   = load_data << (LEN_MAX - len_eff);
    assign handshake = (state_q == IDLE) && load_valid;

    bit_period_ctr #(.DIV_W(DIV_W)) u_bpc (
        .clk   (clk),
        .clr   (clr),
        .start (handshake),
        .div   (div_q),
        .tick  (tick)
    );

    always_comb begin
        state_d  = state_q;
        shreg_d  = shreg_q;
        saved_d  = saved_q;
        len_d    = len_q;
        bitcnt_d = bitcnt_q;
        div_d    = div_q;
        sdout_d  = 1'b0;
        stb_d    = 1'b0;

        case (state_q)
            IDLE: begin
                // abort is ignored here; a load is still taken
                if (load_valid) begin
                    state_d  = SHIFT;
                    saved_d  = aligned;
                    shreg_d  = aligned << 1;
                    len_d    = len_eff;
                    bitcnt_d = len_eff;
                    div_d    = div;
                    sdout_d  = aligned[DATA_W-1];
                    stb_d    = 1'b1;
                end
            end
            SHIFT: begin
                sdout_d = sdout_q;
                if (abort) begin
                    state_d = IDLE;
                    sdout_d = 1'b0;
                end else if (tick) begin
                    if (bitcnt_q > LEN_W'(1)) begin
                        sdout_d  = shreg_q[DATA_W-1];
                        shreg_d  = shreg_q << 1;
                        bitcnt_d = bitcnt_q - 1'b1;
                        stb_d    = 1'b1;
                    end else if (repeat_en) begin
                        // reload straight from the saved copy: no gap cycle
                        sdout_d  = saved_q[DATA_W-1];
                        shreg_d  = saved_q << 1;
                        bitcnt_d = len_q;
                        stb_d    = 1'b1;
                    end else begin
                        state_d = DONE;
                        sdout_d = 1'b0;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        ready_d = (state_d == IDLE);
        busy_d  = (state_d == SHIFT);
        done_d  = (state_d == DONE);
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q  <= IDLE;
            shreg_q  <= '0;
            saved_q  <= '0;
            len_q    <= '0;
            bitcnt_q <= '0;
            div_q    <= '0;
            sdout_q  <= 1'b0;
            stb_q    <= 1'b0;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
            ready_q  <= 1'b1;
        end else begin
            state_q  <= state_d;
            shreg_q  <= shreg_d;
            saved_q  <= saved_d;
            len_q    <= len_d;
            bitcnt_q <= bitcnt_d;
            div_q    <= div_d;
            sdout_q  <= sdout_d;
            stb_q    <= stb_d;
            done_q   <= done_d;
            busy_q   <= busy_d;
            ready_q  <= ready_d;
        end
    end

    assign load_ready = ready_q;
    assign sdout      = sdout_q;
    assign sdout_stb  = stb_q;
    assign done       = done_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_serial_pattern_gen.sv
// Scoreboard bench: each word pushes its expected per-cycle outputs when it
// is driven; a negedge monitor pops and compares one record per cycle.
module tb_serial_pattern_gen;

    logic       clk = 1'b0;
    logic       clr = 1'b1;
    logic [7:0] load_data = '0;
    logic [3:0] load_len = '0;
    logic       load_valid = 1'b0;
    logic       load_ready;
    logic [3:0] div = '0;
    logic       repeat_en = 1'b0;
    logic       abort = 1'b0;
    logic       sdout, sdout_stb, done, busy;

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct {
        logic sd;
        logic stb;
        logic dn;
        logic rdy;
        logic bsy;
        int   cyc;
    } exp_t;

    exp_t q[$];

    always #5 clk = ~clk;

    serial_pattern_gen dut (
        .clk        (clk),
        .clr        (clr),
        .load_data  (load_data),
        .load_len   (load_len),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .div        (div),
        .repeat_en  (repeat_en),
        .abort      (abort),
        .sdout      (sdout),
        .sdout_stb  (sdout_stb),
        .done       (done),
        .busy       (busy)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s act=%0h exp=%0h", tag, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            chk($sformatf("sdout@c%0d", e.cyc), 32'(sdout), 32'(e.sd));
            chk($sformatf("stb@c%0d", e.cyc), 32'(sdout_stb), 32'(e.stb));
            chk($sformatf("done@c%0d", e.cyc), 32'(done), 32'(e.dn));
            chk($sformatf("ready@c%0d", e.cyc), 32'(load_ready), 32'(e.rdy));
            chk($sformatf("busy@c%0d", e.cyc), 32'(busy), 32'(e.bsy));
        end
    end

    function automatic exp_t mk(input logic sd, stb, dn, rdy, bsy, input int cyc);
        exp_t e;
        e.sd = sd; e.stb = stb; e.dn = dn; e.rdy = rdy; e.bsy = bsy; e.cyc = cyc;
        return e;
    endfunction

    // Called at posedge+1 with the DUT idle. abort_at>0 raises abort during
    // that cycle; abort_idle raises abort together with the load; load_in_done
    // presents a second load during the done cycle, which must be ignored.
    task automatic run_word(input logic [7:0] d, input int len_in, input int dv,
                            input int reps, input int abort_at,
                            input bit abort_idle, input bit load_in_done);
        int len_eff, nbits, nb, cyc;
        len_eff = (len_in == 0 || len_in > 8) ? 8 : len_in;
        nbits   = reps * len_eff * (dv + 1);

        load_data  = d;
        load_len   = 4'(len_in);
        div        = 4'(dv);
        repeat_en  = (reps > 1);
        abort      = abort_idle;
        load_valid = 1'b1;

        q.push_back(mk(0, 0, 0, 1, 0, 0));
        nb = 0;
        for (int r = 0; r < reps; r++)
            for (int i = 0; i < len_eff; i++)
                for (int k = 0; k <= dv; k++) begin
                    if (abort_at == 0 || nb < abort_at)
                        q.push_back(mk(d[len_eff-1-i], k == 0, 0, 0, 1, nb + 1));
                    nb++;
                end
        if (abort_at > 0) begin
            q.push_back(mk(0, 0, 0, 1, 0, abort_at + 1));
            q.push_back(mk(0, 0, 0, 1, 0, abort_at + 2));
        end else begin
            q.push_back(mk(0, 0, 1, 0, 0, nbits + 1));
            q.push_back(mk(0, 0, 0, 1, 0, nbits + 2));
            if (load_in_done) q.push_back(mk(0, 0, 0, 1, 0, nbits + 3));
        end

        cyc = 0;
        while (q.size() > 0) begin
            @(posedge clk); #1;
            cyc++;
            if (cyc == 1) begin
                load_valid = 1'b0;
                abort      = 1'b0;
            end
            if (reps > 1 && cyc == (reps - 1) * len_eff * (dv + 1) + 1) repeat_en = 1'b0;
            if (abort_at > 0 && cyc == abort_at)     abort = 1'b1;
            if (abort_at > 0 && cyc == abort_at + 1) abort = 1'b0;
            if (load_in_done && cyc == nbits + 1)    load_valid = 1'b1;
            if (load_in_done && cyc == nbits + 2)    load_valid = 1'b0;
            if (cyc > 3000) begin
                chk("timeout", 32'(cyc), 32'd0);
                q.delete();
            end
        end
        load_valid = 1'b0;
        abort      = 1'b0;
        repeat_en  = 1'b0;
    endtask

    initial begin
        #12;
        chk("rst_ready", 32'(load_ready), 32'd1);
        chk("rst_sdout", 32'(sdout), 32'd0);
        chk("rst_stb", 32'(sdout_stb), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        @(negedge clk); clr = 1'b0;
        @(posedge clk); #1;

        run_word(8'b10001, 5, 0, 1, 0, 0, 0);   // basic word
        run_word(8'b10001, 5, 3, 1, 0, 0, 0);   // 4-cycle bits
        run_word(8'b10001, 5, 0, 3, 0, 0, 0);   // repeat, then stop
        run_word(8'hA5,    0, 0, 1, 0, 0, 0);   // len 0 -> 8 bits
        run_word(8'h3C,   12, 1, 1, 0, 0, 0);   // len >DATA_W -> 8 bits
        run_word(8'h01,    1, 15, 1, 0, 0, 0);  // 1-bit word, max period
        run_word(8'b10001, 5, 0, 1, 3, 0, 0);   // abort in third bit
        run_word(8'b10,    2, 1, 1, 0, 1, 0);   // abort in IDLE ignored
        run_word(8'b10001, 5, 0, 1, 0, 0, 1);   // load in DONE ignored

        // clr mid-word: immediate idle, then a load right after release
        load_data = 8'hFF; load_len = 4'd8; div = 4'd3; load_valid = 1'b1;
        @(posedge clk); #1;
        load_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("pre_clr_busy", 32'(busy), 32'd1);
        clr = 1'b1;
        #1;
        chk("clr_busy", 32'(busy), 32'd0);
        chk("clr_sdout", 32'(sdout), 32'd0);
        chk("clr_ready", 32'(load_ready), 32'd1);
        chk("clr_stb", 32'(sdout_stb), 32'd0);
        #1 clr = 1'b0;
        run_word(8'b10110, 5, 0, 1, 0, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
